store_commit_queue: RTL and testbench

Downstream stage of the store unit. It buffers translated stores in a speculative queue until the scoreboard commits them, then moves them to a commit queue that drains to the D$ write port through a req/gnt handshake. It also provides the page-offset match used by the load unit to stall on possible store-to-load hazards.

---
 rtl/store_commit_queue_pkg.sv | 22 ++
 rtl/store_queue_ring.sv | 68 ++++++
 rtl/store_commit_queue.sv | 112 +++++++++++
 tb/tb_store_commit_queue.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_commit_queue_pkg.sv
// Shared types and helpers for the store commit queue and its ring buffers.
package store_commit_queue_pkg;

    localparam int unsigned PLEN = 56;
    localparam int unsigned XLEN = 64;
    localparam int unsigned BE_W = XLEN / 8;

    typedef struct packed {
        logic [PLEN-1:0] paddr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
        logic [1:0]      data_size;
        logic            valid;
    } store_entry_t;

    // Loads and stores may alias when they touch the same 8-byte word in the page.
    function automatic logic offset_match(input logic [PLEN-1:0] paddr,
                                          input logic [11:0]     page_offset);
        return paddr[11:3] == page_offset[11:3];
    endfunction

endpackage

// File: rtl/store_queue_ring.sv
// Power-of-two circular FIFO with clear; exposes its storage for associative compares.
module store_queue_ring #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o,
    output entry_t           head_o,
    output entry_t           entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] valid_q;
    entry_t           mem_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            // Pop before push so a full-queue push+pop leaves the slot valid.
            if (pop_i) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            end
            if (push_i) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the payload array has no reset; valid_q alone decides whether a slot
    // means anything, which keeps the storage a plain RAM-style array.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/store_commit_queue.sv
// Speculative and commit store queues feeding the D$ write port, plus load hazard check.
module store_commit_queue
    import store_commit_queue_pkg::*;
#(
    parameter int unsigned DEPTH_SPEC   = 4,
    parameter int unsigned DEPTH_COMMIT = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic            valid_without_flush_i,
    output logic            ready_o,
    input  logic [PLEN-1:0] paddr_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [BE_W-1:0] be_i,
    input  logic [1:0]      data_size_i,
    input  logic            commit_i,
    output logic            commit_ready_o,
    input  logic [11:0]     page_offset_i,
    output logic            page_offset_matches_o,
    output logic            no_st_pending_o,
    output logic            store_buffer_empty_o,
    output logic            data_req_o,
    input  logic            data_gnt_i,
    output logic [PLEN-1:0] data_paddr_o,
    output logic [XLEN-1:0] data_wdata_o,
    output logic [BE_W-1:0] data_be_o,
    output logic [1:0]      data_size_o
);

    localparam int unsigned SPEC_CNT_W   = $clog2(DEPTH_SPEC) + 1;
    localparam int unsigned COMMIT_CNT_W = $clog2(DEPTH_COMMIT) + 1;
    localparam logic [SPEC_CNT_W-1:0]   SPEC_READY_LIM = SPEC_CNT_W'(DEPTH_SPEC - 1);
    localparam logic [COMMIT_CNT_W-1:0] COMMIT_FULL    = COMMIT_CNT_W'(DEPTH_COMMIT);

    store_entry_t              push_entry, spec_head, commit_head;
    store_entry_t              spec_entries   [DEPTH_SPEC];
    store_entry_t              commit_entries [DEPTH_COMMIT];
    logic [DEPTH_SPEC-1:0]     spec_valid;
    logic [DEPTH_COMMIT-1:0]   commit_valid;
    logic [SPEC_CNT_W-1:0]     spec_count;
    logic [COMMIT_CNT_W-1:0]   commit_count;
    logic                      spec_push, drain_pop;
    logic                      unused_head_valid;

    assign push_entry = '{paddr: paddr_i, data: data_i, be: be_i,
                          data_size: data_size_i, valid: 1'b1};
    assign spec_push  = valid_i && !flush_i;
    assign drain_pop  = data_gnt_i && data_req_o;

    // A commit coinciding with a flush still pops the head into the commit ring,
    // because the commit ring samples spec_head before the clear takes effect.
    store_queue_ring #(.DEPTH(DEPTH_SPEC), .entry_t(store_entry_t)) i_spec_ring (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (spec_push),
        .push_data_i (push_entry),
        .pop_i       (commit_i),
        .clear_i     (flush_i),
        .count_o     (spec_count),
        .head_o      (spec_head),
        .entries_o   (spec_entries),
        .valid_o     (spec_valid)
    );

    store_queue_ring #(.DEPTH(DEPTH_COMMIT), .entry_t(store_entry_t)) i_commit_ring (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (commit_i),
        .push_data_i (spec_head),
        .pop_i       (drain_pop),
        .clear_i     (1'b0),
        .count_o     (commit_count),
        .head_o      (commit_head),
        .entries_o   (commit_entries),
        .valid_o     (commit_valid)
    );

    // One spare slot covers the push already in flight when ready drops.
    assign ready_o              = spec_count < SPEC_READY_LIM;
    assign commit_ready_o       = commit_count < COMMIT_FULL;
    assign data_req_o           = commit_count != '0;
    assign store_buffer_empty_o = commit_count == '0;
    assign no_st_pending_o      = (spec_count == '0) && (commit_count == '0);

    assign data_paddr_o      = commit_head.paddr;
    assign data_wdata_o      = commit_head.data;
    assign data_be_o         = commit_head.be;
    assign data_size_o       = commit_head.data_size;
    assign unused_head_valid = commit_head.valid;

    // NOTE: the output gets its default before the loops, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        page_offset_matches_o = valid_without_flush_i && offset_match(paddr_i, page_offset_i);
        for (int i = 0; i < int'(DEPTH_SPEC); i++) begin
            if (spec_valid[i] && offset_match(spec_entries[i].paddr, page_offset_i)) begin
                page_offset_matches_o = 1'b1;
            end
        end
        for (int i = 0; i < int'(DEPTH_COMMIT); i++) begin
            if (commit_valid[i] && offset_match(commit_entries[i].paddr, page_offset_i)) begin
                page_offset_matches_o = 1'b1;
            end
        end
    end

    a_commit_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        commit_i |-> (spec_count != '0) && commit_ready_o);

endmodule

// File: tb/tb_store_commit_queue.sv
// Self-checking bench: vector table, directed corner sequences, and random traffic vs a queue model.
module tb_store_commit_queue;
    import store_commit_queue_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n, flush, valid, vwf, commit, gnt;
    logic [PLEN-1:0] paddr;
    logic [XLEN-1:0] data;
    logic [BE_W-1:0] be;
    logic [1:0]      size;
    logic [11:0]     poff;
    logic            ready_o, commit_ready_o, match_o, no_st_pending_o, sb_empty_o, data_req_o;
    logic [PLEN-1:0] data_paddr_o;
    logic [XLEN-1:0] data_wdata_o;
    logic [BE_W-1:0] data_be_o;
    logic [1:0]      data_size_o;

    always #5 clk = ~clk;

    store_commit_queue dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .flush_i               (flush),
        .valid_i               (valid),
        .valid_without_flush_i (vwf),
        .ready_o               (ready_o),
        .paddr_i               (paddr),
        .data_i                (data),
        .be_i                  (be),
        .data_size_i           (size),
        .commit_i              (commit),
        .commit_ready_o        (commit_ready_o),
        .page_offset_i         (poff),
        .page_offset_matches_o (match_o),
        .no_st_pending_o       (no_st_pending_o),
        .store_buffer_empty_o  (sb_empty_o),
        .data_req_o            (data_req_o),
        .data_gnt_i            (gnt),
        .data_paddr_o          (data_paddr_o),
        .data_wdata_o          (data_wdata_o),
        .data_be_o             (data_be_o),
        .data_size_o           (data_size_o)
    );

    typedef struct {
        logic [PLEN-1:0] paddr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
        logic [1:0]      size;
    } st_t;

    typedef struct packed {
        logic            valid, flush, commit, gnt, vwf;
        logic [PLEN-1:0] paddr;
        logic [11:0]     poff;
        logic            ready, cready, req, nop, sbe, match;
    } vec_t;

    st_t             spec_m[$];
    st_t             com_m[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    int              push_idx, push_lim, n_drained;
    logic [PLEN-1:0] push_base;
    vec_t            tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        valid = 0; flush = 0; commit = 0; gnt = 0; vwf = 0;
        paddr = '0; data = '0; be = '0; size = '0; poff = '0;
    endtask

    task automatic push_store(input logic [PLEN-1:0] a);
        valid = 1; vwf = 1; paddr = a;
        data  = XLEN'(a) ^ 64'h0123_4567_89AB_CDEF;
        be    = 8'hFF; size = 2'b11;
    endtask

    function automatic logic model_match();
        logic m = vwf && (paddr[11:3] == poff[11:3]);
        foreach (spec_m[i]) if (spec_m[i].paddr[11:3] == poff[11:3]) m = 1'b1;
        foreach (com_m[i])  if (com_m[i].paddr[11:3]  == poff[11:3]) m = 1'b1;
        return m;
    endfunction

    // Compare all outputs against the model, then clock once and advance the model.
    task automatic cycle();
        st_t cur;
        #1;
        check($sformatf("c%0d ready_o", cyc), ready_o, spec_m.size() < 3);
        check($sformatf("c%0d commit_ready_o", cyc), commit_ready_o, com_m.size() < 8);
        check($sformatf("c%0d data_req_o", cyc), data_req_o, com_m.size() != 0);
        check($sformatf("c%0d no_st_pending_o", cyc), no_st_pending_o,
              spec_m.size() == 0 && com_m.size() == 0);
        check($sformatf("c%0d store_buffer_empty_o", cyc), sb_empty_o, com_m.size() == 0);
        check($sformatf("c%0d page_offset_matches_o", cyc), match_o, model_match());
        if (com_m.size() != 0) begin
            check($sformatf("c%0d data_paddr_o", cyc), data_paddr_o, com_m[0].paddr);
            check($sformatf("c%0d data_wdata_o", cyc), data_wdata_o, com_m[0].data);
            check($sformatf("c%0d data_be_o", cyc), data_be_o, com_m[0].be);
            check($sformatf("c%0d data_size_o", cyc), data_size_o, com_m[0].size);
        end
        cur.paddr = paddr; cur.data = data; cur.be = be; cur.size = size;
        @(posedge clk);
        if (!rst_n) begin
            spec_m.delete();
            com_m.delete();
        end else begin
            if (gnt && com_m.size() != 0) void'(com_m.pop_front());
            if (commit) com_m.push_back(spec_m.pop_front());
            if (flush) spec_m.delete();
            else if (valid) spec_m.push_back(cur);
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        @(posedge clk);
        spec_m.delete();
        com_m.delete();
        #1;
        rst_n = 1;
    endtask

    // One cycle of streaming traffic: push the next address if the spec queue has
    // room, commit if legal, and check each granted drain is the next address in order.
    task automatic step_stream(input logic g, input logic allow_commit);
        idle();
        if (push_idx < push_lim && spec_m.size() < 3) begin
            push_store(push_base + PLEN'(8 * push_idx));
            push_idx++;
        end
        if (allow_commit && spec_m.size() != 0 && com_m.size() < 8) commit = 1;
        gnt = g;
        #1;
        if (data_req_o && gnt) begin
            check("drain order", data_paddr_o, push_base + PLEN'(8 * n_drained));
            n_drained++;
        end
        cycle();
    endtask

    task automatic drain_all();
        for (int k = 0; k < 64 && (spec_m.size() != 0 || com_m.size() != 0); k++) begin
            idle();
            if (spec_m.size() != 0 && com_m.size() < 8) commit = 1;
            gnt = 1;
            cycle();
        end
        check("drain_all empties", no_st_pending_o, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            vld flu com gnt vwf paddr         poff     rdy crdy req nop sbe mat
        tbl[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 56'h0,    12'h000, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b0};
        tbl[1] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 56'h1238, 12'h23C, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b1};
        tbl[2] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 56'h0100, 12'h23C, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1};
        tbl[3] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 56'h0200, 12'h240, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
        tbl[4] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 56'h0,    12'h240, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
        tbl[5] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 56'h0,    12'h23C, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1};
        tbl[6] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 56'h0,    12'h23C, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1};
        tbl[7] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 56'h1238, 12'h100, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1};
        tbl[8] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 56'h5240, 12'h240, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b1};
        tbl[9] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 56'h0,    12'h240, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b0};

        do_reset();
        idle();
        #1;
        check("reset ready_o", ready_o, 1'b1);
        check("reset commit_ready_o", commit_ready_o, 1'b1);
        check("reset data_req_o", data_req_o, 1'b0);
        check("reset no_st_pending_o", no_st_pending_o, 1'b1);
        check("reset store_buffer_empty_o", sb_empty_o, 1'b1);
        check("reset page_offset_matches_o", match_o, 1'b0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            idle();
            valid = tbl[i].valid; flush = tbl[i].flush; commit = tbl[i].commit;
            gnt = tbl[i].gnt; vwf = tbl[i].vwf; paddr = tbl[i].paddr; poff = tbl[i].poff;
            data = XLEN'(tbl[i].paddr); be = 8'hFF; size = 2'b11;
            #1;
            check($sformatf("vec%0d ready_o", i), ready_o, tbl[i].ready);
            check($sformatf("vec%0d commit_ready_o", i), commit_ready_o, tbl[i].cready);
            check($sformatf("vec%0d data_req_o", i), data_req_o, tbl[i].req);
            check($sformatf("vec%0d no_st_pending_o", i), no_st_pending_o, tbl[i].nop);
            check($sformatf("vec%0d store_buffer_empty_o", i), sb_empty_o, tbl[i].sbe);
            check($sformatf("vec%0d match", i), match_o, tbl[i].match);
            cycle();
        end

        // Single store: push, commit, drain under held grant
        do_reset();
        idle();
        valid = 1; vwf = 1; paddr = 56'h8000_0010; data = 64'hDEAD_BEEF; be = 8'h0F; size = 2'b10;
        cycle();
        idle(); commit = 1; gnt = 1;
        cycle();
        idle(); gnt = 1;
        #1;
        check("single data_req_o", data_req_o, 1'b1);
        check("single data_paddr_o", data_paddr_o, 56'h8000_0010);
        check("single data_wdata_o", data_wdata_o, 64'hDEAD_BEEF);
        check("single data_be_o", data_be_o, 8'h0F);
        cycle();
        check("single no_st_pending_o", no_st_pending_o, 1'b1);

        // ready_o back-pressure and push landing at full-minus-one with commit
        for (int i = 0; i < 3; i++) begin
            idle(); push_store(56'h100 + 56'(8 * i)); cycle();
        end
        check("three pushes ready_o", ready_o, 1'b0);
        idle(); push_store(56'h118); commit = 1; cycle();
        check("push+commit ready_o", ready_o, 1'b0);
        idle(); commit = 1; cycle();
        check("commit frees ready_o", ready_o, 1'b1);
        drain_all();

        // Flush with a concurrent push leaves only the committed store
        idle(); push_store(56'h200); cycle();
        idle(); push_store(56'h208); cycle();
        idle(); commit = 1; cycle();
        idle(); push_store(56'h210); flush = 1; cycle();
        idle();
        #1;
        check("flush store_buffer_empty_o", sb_empty_o, 1'b0);
        check("flush no_st_pending_o", no_st_pending_o, 1'b0);
        check("flush data_paddr_o", data_paddr_o, 56'h200);
        gnt = 1;
        cycle();
        check("flush drained no_st_pending_o", no_st_pending_o, 1'b1);

        // Fill commit queue, release one slot, then stream 16 stores across wrap
        push_base = '0; push_idx = 0; push_lim = 16; n_drained = 0;
        for (int k = 0; k < 64 && com_m.size() < 8; k++) step_stream(1'b0, 1'b1);
        check("cq full commit_ready_o", commit_ready_o, 1'b0);
        step_stream(1'b1, 1'b0);
        check("one gnt commit_ready_o", commit_ready_o, 1'b1);
        for (int k = 0; k < 200 && n_drained < 16; k++) step_stream(1'b1, 1'b1);
        check("drained count", 64'(n_drained), 64'd16);

        // Reset while five stores are pending and a grant is present
        push_base = 56'h400; push_idx = 0; push_lim = 5; n_drained = 0;
        for (int k = 0; k < 64 && com_m.size() < 5; k++) step_stream(1'b0, 1'b1);
        check("pre-reset data_req_o", data_req_o, 1'b1);
        idle(); gnt = 1; rst_n = 0;
        cycle();
        rst_n = 1;
        idle();
        #1;
        check("mid-drain reset data_req_o", data_req_o, 1'b0);
        check("mid-drain reset no_st_pending_o", no_st_pending_o, 1'b1);
        check("mid-drain reset ready_o", ready_o, 1'b1);

        // Random legal traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            logic [8:0] off_w;
            idle();
            rst_n  = ($urandom_range(0, 499) != 0);
            flush  = ($urandom_range(0, 15) == 0);
            commit = (spec_m.size() != 0 && com_m.size() < 8 && $urandom_range(0, 1) == 1);
            if (spec_m.size() + 1 - int'(commit) <= 4 && $urandom_range(0, 2) != 0) begin
                off_w = 9'($urandom_range(0, 15));
                valid = 1;
                paddr = {44'({$urandom(), $urandom()}), off_w, 3'($urandom_range(0, 7))};
                data  = {$urandom(), $urandom()};
                be    = 8'($urandom());
                size  = 2'($urandom());
            end
            vwf = valid | ($urandom_range(0, 3) == 0);
            gnt = ($urandom_range(0, 2) != 0);
            off_w = 9'($urandom_range(0, 15));
            poff = {off_w, 3'($urandom_range(0, 7))};
            cycle();
            rst_n = 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
